// File: rtl/request_arbiter_if.sv
// Request/grant bundle between the requesting units and the arbiter; slave is the arbiter side.
interface request_arbiter_if;
    logic [4:1] req;
    logic       done;
    logic [4:1] gnt;
    logic [2:0] gcode;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gcode,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gcode,
        output busy,
        output timeout
    );
endinterface

// File: rtl/request_arbiter.sv
// Four-way hold-until-release arbiter: grant one cycle after req, release one cycle after done/req drop/limit.
// No backpressure; a mandatory IDLE gap follows every release. `ROUND_ROBIN_EN selects rotating priority.
module request_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    request_arbiter_if.slave   bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0] state;
    logic [4:1] gnt_r;
    logic [2:0] gcode_r;
    logic       busy_r;
    logic       timeout_r;
    logic [7:0] hold_cnt;
    logic [2:0] win;
    logic       owner_req;
    logic       at_limit;

    function automatic logic [4:1] onehot(input logic [2:0] code);
        logic [4:1] m;
        case (code)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0010;
            3'd3:    m = 4'b0100;
            3'd4:    m = 4'b1000;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic active(input logic [4:1] r, input logic [2:0] code);
        return |(r & onehot(code));
    endfunction

`ifdef ROUND_ROBIN_EN
    logic [2:0] last;

    // First active requester in the order p0,p1,p2,p3; p3 is always the previous owner.
    function automatic logic [2:0] first_of(input logic [4:1] r,
                                            input logic [2:0] p0, input logic [2:0] p1,
                                            input logic [2:0] p2, input logic [2:0] p3);
        logic [2:0] w;
        if (active(r, p0))      w = p0;
        else if (active(r, p1)) w = p1;
        else if (active(r, p2)) w = p2;
        else if (active(r, p3)) w = p3;
        else                    w = 3'd0;
        return w;
    endfunction

    always_comb begin
        win = 3'd0;
        case (last)
            3'd2:    win = first_of(bus.req, 3'd1, 3'd4, 3'd3, 3'd2);
            3'd3:    win = first_of(bus.req, 3'd2, 3'd1, 3'd4, 3'd3);
            3'd4:    win = first_of(bus.req, 3'd3, 3'd2, 3'd1, 3'd4);
            default: win = first_of(bus.req, 3'd4, 3'd3, 3'd2, 3'd1);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 3'd1;
        end else if (state == GRANT && (bus.done || !owner_req || at_limit)) begin
            last <= gcode_r;
        end
    end
`else
    always_comb begin
        win = 3'd0;
        if (bus.req[4])      win = 3'd4;
        else if (bus.req[3]) win = 3'd3;
        else if (bus.req[2]) win = 3'd2;
        else if (bus.req[1]) win = 3'd1;
    end
`endif

    assign owner_req = |(bus.req & gnt_r);
    assign at_limit  = (hold_cnt == 8'(MAX_HOLD));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt_r     <= 4'b0000;
            gcode_r   <= 3'd0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            hold_cnt  <= 8'd0;
        end else begin
            timeout_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (win != 3'd0) begin
                        state    <= GRANT;
                        gnt_r    <= onehot(win);
                        gcode_r  <= win;
                        busy_r   <= 1'b1;
                        hold_cnt <= 8'd1;
                    end
                end
                default: begin
                    // done outranks the limit, so a finish on the last allowed cycle is not a timeout
                    if (bus.done || !owner_req || at_limit) begin
                        state     <= IDLE;
                        gnt_r     <= 4'b0000;
                        gcode_r   <= 3'd0;
                        busy_r    <= 1'b0;
                        hold_cnt  <= 8'd0;
                        timeout_r <= !bus.done && owner_req;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.gcode   = gcode_r;
    assign bus.busy    = busy_r;
    assign bus.timeout = timeout_r;

endmodule
